// File: rtl/pkt_framer.sv
// pkt_framer: packs an 18-bit sample stream into frames of the form
//   header {2'b11, 8'hA5, seq} -> PAYLOAD_LEN payload words -> trailer (XOR checksum).
// Input words are buffered in a first-word-fall-through FIFO. The sample source has
// no backpressure, so a push into a full FIFO without a same-cycle pop is dropped
// and flagged on the sticky ovf_err.
//
// Ports:
//   pktctrl_rclk    clock, all logic on the rising edge
//   pktctrl_rrst    asynchronous active-high reset
//   pkt_data        sample word in
//   pkt_data_valid  pkt_data qualifier (one word per high cycle)
//   rf_frame_en     framing enable (level)
//   rf_err_clr      pulse, clears ovf_err
//   frame_data      framed word out
//   frame_valid     frame_data qualifier
//   frame_ready     downstream accept
//   frame_sop       high with the header word
//   frame_eop       high with the trailer word
//   ovf_err         sticky input-overflow flag
//   fifo_level      current FIFO occupancy
module pkt_framer #(
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          pktctrl_rclk,
    input  logic                          pktctrl_rrst,
    input  logic [17:0]                   pkt_data,
    input  logic                          pkt_data_valid,
    input  logic                          rf_frame_en,
    input  logic                          rf_err_clr,
    output logic [17:0]                   frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic                          frame_sop,
    output logic                          frame_eop,
    output logic                          ovf_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_LEN - 1);

    // One-hot FSM encoding
    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_HEADER  = 4'b0010;
    localparam logic [3:0] ST_PAYLOAD = 4'b0100;
    localparam logic [3:0] ST_TRAILER = 4'b1000;

    // ---------------------------------------------------------------------
    // Input FIFO
    // ---------------------------------------------------------------------
    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          fifo_empty, fifo_full;
    logic          push_req, push_ok, pop, overflow;
    logic [17:0]   fifo_head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);
    assign fifo_head  = mem[rd_ptr_q];
    assign fifo_level = level_q;

    assign push_req = pkt_data_valid & rf_frame_en;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok  = push_req & (~fifo_full | pop);
    assign overflow = push_req & fifo_full & ~pop;

    always_ff @(posedge pktctrl_rclk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= pkt_data;
        end
    end

    always_ff @(posedge pktctrl_rclk or posedge pktctrl_rrst) begin
        if (pktctrl_rrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Overflow wins over a same-cycle clear.
    logic ovf_d;
    always_comb begin
        ovf_d = ovf_err;
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (rf_err_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge pktctrl_rclk or posedge pktctrl_rrst) begin
        if (pktctrl_rrst) begin
            ovf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_d;
        end
    end

    // ---------------------------------------------------------------------
    // Framing FSM
    // ---------------------------------------------------------------------
    logic [3:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  seq_q, seq_d;
    logic [17:0] csum_q, csum_d;
    logic        pad_hold_q, pad_hold_d;
    logic        pad_sel, xfer;

    // Pad once the source is disabled and drained. A stalled pad word is latched
    // so a late re-enable cannot swap the presented word under the consumer.
    assign pad_sel = pad_hold_q | (fifo_empty & ~rf_frame_en);
    assign xfer    = frame_valid & frame_ready;
    assign pop     = (state_q == ST_PAYLOAD) & xfer & ~pad_sel;

    always_comb begin
        frame_valid = 1'b0;
        frame_sop   = 1'b0;
        frame_eop   = 1'b0;
        frame_data  = '0;
        unique case (state_q)
            ST_HEADER: begin
                frame_valid = 1'b1;
                frame_sop   = 1'b1;
                frame_data  = {2'b11, 8'hA5, seq_q};
            end
            ST_PAYLOAD: begin
                if (pad_sel) begin
                    frame_valid = 1'b1;
                end else begin
                    frame_valid = ~fifo_empty;
                    frame_data  = fifo_head;
                end
            end
            ST_TRAILER: begin
                frame_valid = 1'b1;
                frame_eop   = 1'b1;
                frame_data  = csum_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        pad_hold_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && rf_frame_en) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (xfer) begin
                    state_d = ST_PAYLOAD;
                    csum_d  = '0;
                end
            end
            ST_PAYLOAD: begin
                pad_hold_d = pad_sel & ~frame_ready;
                if (xfer) begin
                    csum_d = csum_q ^ frame_data;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_TRAILER;
                    end else begin
                        cnt_d = cnt_q + 8'(1);
                    end
                end
            end
            ST_TRAILER: begin
                if (xfer) begin
                    seq_d   = seq_q + 8'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pktctrl_rclk or posedge pktctrl_rrst) begin
        if (pktctrl_rrst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seq_q      <= '0;
            csum_q     <= '0;
            pad_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            pad_hold_q <= pad_hold_d;
        end
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer with PAYLOAD_LEN=4, FIFO_DEPTH=16.
module tb_pkt_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] pkt_data = '0;
    logic        pkt_data_valid = 1'b0;
    logic        rf_frame_en = 1'b0;
    logic        rf_err_clr = 1'b0;
    logic [17:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        frame_sop;
    logic        frame_eop;
    logic        ovf_err;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    pkt_framer #(
        .PAYLOAD_LEN(4),
        .FIFO_DEPTH (16)
    ) dut (
        .pktctrl_rclk  (clk),
        .pktctrl_rrst  (rst),
        .pkt_data      (pkt_data),
        .pkt_data_valid(pkt_data_valid),
        .rf_frame_en   (rf_frame_en),
        .rf_err_clr    (rf_err_clr),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_sop     (frame_sop),
        .frame_eop     (frame_eop),
        .ovf_err       (ovf_err),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [17:0] d;
        logic        e_valid;
        logic [17:0] e_data;
        logic        e_sop;
        logic        e_eop;
        logic [4:0]  e_level;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic v, logic [17:0] d, logic ev, logic [17:0] ed,
                                logic s, logic e, logic [4:0] l);
        vec_t r;
        r.vld = v; r.d = d; r.e_valid = ev; r.e_data = ed;
        r.e_sop = s; r.e_eop = e; r.e_level = l;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pkt_data_valid = 1'b0;
        rf_err_clr = 1'b0;
        frame_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Waits for one transfer and compares {sop, eop, data}.
    task automatic expect_xfer(input string name, input logic [19:0] exp);
        bit got_it = 0;
        logic [19:0] w = '0;
        for (int i = 0; i < 200 && !got_it; i++) begin
            @(negedge clk);
            if (frame_valid && frame_ready) begin
                w = {frame_sop, frame_eop, frame_data};
                got_it = 1;
            end
            cyc();
        end
        if (!got_it) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got none expected %h", name, exp);
        end else begin
            chk(name, 32'(w), 32'(exp));
        end
    endtask

    task automatic push_words(input logic [17:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            pkt_data_valid = 1'b1;
            pkt_data = base + 18'(i);
            cyc();
        end
        pkt_data_valid = 1'b0;
    endtask

    initial begin
        // Reset state is visible while reset is held
        #1;
        chk("reset_outputs", 32'({frame_valid, frame_sop, frame_eop, ovf_err, fifo_level,
                                  frame_data}), 32'(0));
        do_reset();

        // ----- Table: two back-to-back frames, ready held high -----
        tbl[0]  = mk(1, 18'h1, 0, 18'h0,     0, 0, 0);
        tbl[1]  = mk(1, 18'h2, 0, 18'h0,     0, 0, 1);
        tbl[2]  = mk(1, 18'h3, 1, 18'h3A500, 1, 0, 2);
        tbl[3]  = mk(1, 18'h4, 1, 18'h1,     0, 0, 3);
        tbl[4]  = mk(0, 18'h0, 1, 18'h2,     0, 0, 3);
        tbl[5]  = mk(0, 18'h0, 1, 18'h3,     0, 0, 2);
        tbl[6]  = mk(0, 18'h0, 1, 18'h4,     0, 0, 1);
        tbl[7]  = mk(0, 18'h0, 1, 18'h4,     0, 1, 0);
        tbl[8]  = mk(1, 18'h5, 0, 18'h0,     0, 0, 0);
        tbl[9]  = mk(1, 18'h6, 0, 18'h0,     0, 0, 1);
        tbl[10] = mk(1, 18'h7, 1, 18'h3A501, 1, 0, 2);
        tbl[11] = mk(1, 18'h8, 1, 18'h5,     0, 0, 3);
        tbl[12] = mk(0, 18'h0, 1, 18'h6,     0, 0, 3);
        tbl[13] = mk(0, 18'h0, 1, 18'h7,     0, 0, 2);
        tbl[14] = mk(0, 18'h0, 1, 18'h8,     0, 0, 1);
        tbl[15] = mk(0, 18'h0, 1, 18'hC,     0, 1, 0);
        tbl[16] = mk(0, 18'h0, 0, 18'h0,     0, 0, 0);

        rf_frame_en = 1'b1;
        frame_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pkt_data_valid = tbl[i].vld;
            pkt_data = tbl[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                32'({frame_valid, frame_sop, frame_eop, fifo_level, frame_data}),
                32'({tbl[i].e_valid, tbl[i].e_sop, tbl[i].e_eop, tbl[i].e_level,
                     tbl[i].e_data}));
            cyc();
        end
        pkt_data_valid = 1'b0;

        // ----- Disable mid-frame: two real words then zero padding -----
        frame_ready = 1'b0;
        push_words(18'h11, 1);
        push_words(18'h22, 1);
        rf_frame_en = 1'b0;
        frame_ready = 1'b1;
        expect_xfer("pad_hdr", {2'b10, 18'h3A502});
        expect_xfer("pad_w0",  {2'b00, 18'h11});
        expect_xfer("pad_w1",  {2'b00, 18'h22});
        expect_xfer("pad_w2",  {2'b00, 18'h0});
        expect_xfer("pad_w3",  {2'b00, 18'h0});
        expect_xfer("pad_trl", {2'b01, 18'h33});
        begin
            logic any_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                any_valid |= frame_valid;
                cyc();
            end
            chk("pad_idle_stays", 32'({any_valid, fifo_level}), 32'(0));
        end

        // ----- Reset while presenting payload word 2 -----
        rf_frame_en = 1'b1;
        frame_ready = 1'b0;
        push_words(18'h101, 4);
        frame_ready = 1'b1;
        expect_xfer("rst_hdr", {2'b10, 18'h3A503});
        expect_xfer("rst_w0",  {2'b00, 18'h101});
        expect_xfer("rst_w1",  {2'b00, 18'h102});
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({frame_valid, frame_sop, frame_eop, ovf_err, fifo_level,
                                      frame_data}), 32'(0));
        cyc();
        rst = 1'b0;
        frame_ready = 1'b0;
        push_words(18'h201, 4);
        frame_ready = 1'b1;
        expect_xfer("post_rst_hdr", {2'b10, 18'h3A500});
        expect_xfer("post_rst_w0",  {2'b00, 18'h201});
        expect_xfer("post_rst_w1",  {2'b00, 18'h202});
        expect_xfer("post_rst_w2",  {2'b00, 18'h203});
        expect_xfer("post_rst_w3",  {2'b00, 18'h204});
        expect_xfer("post_rst_trl", {2'b01, 18'h004});

        // ----- Overflow: 20 pushes into a stalled framer -----
        do_reset();
        rf_frame_en = 1'b1;
        push_words(18'h300, 20);
        @(negedge clk);
        chk("ovf_level", 32'(fifo_level), 32'(16));
        chk("ovf_set", 32'(ovf_err), 32'(1));
        chk("ovf_hdr_held", 32'({frame_valid, frame_sop, frame_data}), 32'({2'b11, 18'h3A500}));
        cyc();
        pkt_data_valid = 1'b1;
        pkt_data = 18'h3FF;
        rf_err_clr = 1'b1;
        cyc();
        pkt_data_valid = 1'b0;
        rf_err_clr = 1'b0;
        @(negedge clk);
        chk("ovf_beats_clr", 32'(ovf_err), 32'(1));
        cyc();
        rf_err_clr = 1'b1;
        cyc();
        rf_err_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(ovf_err), 32'(0));
        cyc();
        frame_ready = 1'b1;
        cyc();
        frame_ready = 1'b0;
        @(negedge clk);
        chk("full_head_w0", 32'({frame_valid, frame_sop, frame_data}), 32'({2'b10, 18'h300}));
        cyc();
        pkt_data_valid = 1'b1;
        pkt_data = 18'h3EE;
        frame_ready = 1'b1;
        cyc();
        pkt_data_valid = 1'b0;
        frame_ready = 1'b0;
        @(negedge clk);
        chk("full_push_pop_level", 32'(fifo_level), 32'(16));
        chk("full_push_pop_no_ovf", 32'(ovf_err), 32'(0));
        chk("full_push_pop_head", 32'(frame_data), 32'(18'h301));
        cyc();

        // ----- Random ready over 257 frames (seq wraps) -----
        do_reset();
        rf_frame_en = 1'b1;
        begin
            logic [17:0] exp_q[$];
            fork
                begin : producer
                    int n = 0;
                    for (int c = 0; c < 40000 && n < 1028; c++) begin
                        cyc();
                        if ($urandom_range(0, 4) == 0) begin
                            pkt_data_valid = 1'b1;
                            pkt_data = 18'($urandom);
                            exp_q.push_back(pkt_data);
                            n++;
                        end else begin
                            pkt_data_valid = 1'b0;
                        end
                    end
                    cyc();
                    pkt_data_valid = 1'b0;
                end
                begin : consumer
                    int pos = 0;
                    int frames = 0;
                    logic [7:0] eseq = '0;
                    logic [17:0] ecsum = '0;
                    logic [17:0] d;
                    logic [19:0] exp_w;
                    logic [19:0] prev_w = '0;
                    bit prev_stall = 0;
                    for (int c = 0; c < 40000 && frames < 257; c++) begin
                        cyc();
                        frame_ready = ($urandom_range(0, 1) == 1);
                        @(negedge clk);
                        if (prev_stall) begin
                            chk("stall_hold",
                                32'({frame_valid, frame_sop, frame_eop, frame_data}),
                                32'({1'b1, prev_w}));
                        end
                        if (frame_valid && frame_ready) begin
                            if (pos == 0) begin
                                exp_w = {2'b10, 2'b11, 8'hA5, eseq};
                                ecsum = '0;
                            end else if (pos == 5) begin
                                exp_w = {2'b01, ecsum};
                            end else if (exp_q.size() == 0) begin
                                exp_w = '1;
                            end else begin
                                d = exp_q.pop_front();
                                ecsum ^= d;
                                exp_w = {2'b00, d};
                            end
                            chk($sformatf("rand_f%0d_p%0d", frames, pos),
                                32'({frame_sop, frame_eop, frame_data}), 32'(exp_w));
                            if (pos == 5) begin
                                pos = 0;
                                eseq++;
                                frames++;
                            end else begin
                                pos++;
                            end
                        end
                        prev_stall = frame_valid && !frame_ready;
                        prev_w = {frame_sop, frame_eop, frame_data};
                    end
                    if (frames < 257) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_timeout got %0d frames expected 257", frames);
                    end
                end
            join
        end
        @(negedge clk);
        chk("rand_no_ovf", 32'(ovf_err), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
